// File: rtl/sdhci_pkg.sv
// Shared types and encodings for the SD host CMD-line arbiter.
// Error struct layout matches the engine's {index, end bit, crc, timeout} bus.
package sdhci_pkg;

  typedef struct packed {
    logic index;
    logic end_bit;
    logic crc;
    logic timeout;
  } cmd_err_t;

  typedef struct packed {
    logic [5:0]  index;
    logic [31:0] arg;
    logic [1:0]  resp_type;
  } cmd_t;

  localparam int unsigned ACMD_ERR_NOT_EXEC   = 0;
  localparam int unsigned ACMD_ERR_TIMEOUT    = 1;
  localparam int unsigned ACMD_ERR_CRC        = 2;
  localparam int unsigned ACMD_ERR_END_BIT    = 3;
  localparam int unsigned ACMD_ERR_INDEX      = 4;
  localparam int unsigned ACMD_ERR_NOT_ISSUED = 7;

  localparam logic [1:0] RESP_NONE    = 2'b00;
  localparam logic [1:0] RESP_136     = 2'b01;
  localparam logic [1:0] RESP_48      = 2'b10;
  localparam logic [1:0] RESP_48_BUSY = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE_DRV = 3'd1,
    ST_WAIT_DRV  = 3'd2,
    ST_ISSUE_ACMD = 3'd3,
    ST_WAIT_ACMD = 3'd4
  } arb_state_t;

  // Places the engine's response error flags into Auto CMD12 Error Status positions.
  function automatic logic [7:0] acmd_err_bits(cmd_err_t e);
    logic [7:0] b;
    b = '0;
    b[ACMD_ERR_TIMEOUT] = e.timeout;
    b[ACMD_ERR_CRC]     = e.crc;
    b[ACMD_ERR_END_BIT] = e.end_bit;
    b[ACMD_ERR_INDEX]   = e.index;
    return b;
  endfunction

endpackage

// File: rtl/sdhci_cmd_req_latch.sv
// One requester slot: a pending flag plus the command captured when it was set.
// A request while already pending is ignored; a clear always wins.
module sdhci_cmd_req_latch
  import sdhci_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic req_i,
  input  cmd_t cmd_i,
  output logic pend_o,
  output cmd_t cmd_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_o <= 1'b0;
      cmd_o  <= '0;
    end else if (clr_i) begin
      pend_o <= 1'b0;
    end else if (req_i && !pend_o) begin
      pend_o <= 1'b1;
      cmd_o  <= cmd_i;
    end
  end

endmodule

// File: rtl/sdhci_cmd_arbiter.sv
// Orders driver commands and Auto CMD12 onto the single CMD line engine and
// owns the Auto CMD12 Error Status register.
module sdhci_cmd_arbiter
  import sdhci_pkg::*;
#(
  parameter logic [5:0]  AcmdIndex    = 6'd12,
  parameter logic [31:0] AcmdArg      = 32'h0,
  parameter logic [1:0]  AcmdRespType = RESP_48_BUSY
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        soft_rst_i,
  input  logic        drv_req_i,
  input  logic [5:0]  drv_index_i,
  input  logic [31:0] drv_arg_i,
  input  logic [1:0]  drv_resp_type_i,
  output logic        drv_done_o,
  output logic [3:0]  drv_err_o,
  input  logic        acmd_req_i,
  output logic        acmd_done_o,
  // Engine handshake: a command transfers on the cycle cmd_valid_o and
  // cmd_ready_i are both high; fields stay stable while valid waits for ready.
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  output logic [1:0]  cmd_resp_type_o,
  input  logic        rsp_done_i,
  input  logic [3:0]  rsp_err_i,
  output logic        cmd_inhibit_o,
  output logic [7:0]  acmd_err_o,
  input  logic [7:0]  acmd_err_clr_i,
  output logic [2:0]  dbg_state_o
);

  arb_state_t state;
  cmd_err_t   rsp_err;
  cmd_t       drv_in, acmd_in, drv_held, acmd_held, drv_eff, acmd_eff;
  logic       drv_pend, acmd_pend;
  logic       drv_fin, acmd_fin, rsp_bad, drop_drv, drop_acmd;
  logic       drv_clr, acmd_clr;
  logic       drop_drv_q, drop_acmd_q;
  logic [7:0] acmd_err_set;

  assign rsp_err = cmd_err_t'(rsp_err_i);
  assign drv_in  = {drv_index_i, drv_arg_i, drv_resp_type_i};
  assign acmd_in = {AcmdIndex, AcmdArg, AcmdRespType};

  assign rsp_bad   = |rsp_err_i;
  assign drv_fin   = (state == ST_WAIT_DRV) && rsp_done_i;
  assign acmd_fin  = (state == ST_WAIT_ACMD) && rsp_done_i;
  // A bad response cancels whichever other command is queued behind it.
  assign drop_drv  = acmd_fin && rsp_bad && drv_pend;
  assign drop_acmd = drv_fin && rsp_bad && acmd_pend;
  assign drv_clr   = soft_rst_i || drv_fin || drop_drv;
  assign acmd_clr  = soft_rst_i || acmd_fin || drop_acmd;

  assign drv_eff  = drv_pend ? drv_held : drv_in;
  assign acmd_eff = acmd_pend ? acmd_held : acmd_in;

  sdhci_cmd_req_latch u_drv_latch (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (drv_clr),
    .req_i  (drv_req_i),
    .cmd_i  (drv_in),
    .pend_o (drv_pend),
    .cmd_o  (drv_held)
  );

  sdhci_cmd_req_latch u_acmd_latch (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (acmd_clr),
    .req_i  (acmd_req_i),
    .cmd_i  (acmd_in),
    .pend_o (acmd_pend),
    .cmd_o  (acmd_held)
  );

  always_comb begin
    acmd_err_set = '0;
    if (!soft_rst_i) begin
      if (acmd_fin) begin
        acmd_err_set = acmd_err_bits(rsp_err);
        acmd_err_set[ACMD_ERR_NOT_ISSUED] = drop_drv;
      end else if (drv_fin) begin
        acmd_err_set[ACMD_ERR_NOT_EXEC] = drop_acmd;
      end
    end
  end

  // Set beats clear; software reset of the CMD line leaves the status intact.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acmd_err_o <= '0;
    else         acmd_err_o <= (acmd_err_o & ~acmd_err_clr_i) | acmd_err_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= ST_IDLE;
      cmd_valid_o     <= 1'b0;
      cmd_index_o     <= '0;
      cmd_arg_o       <= '0;
      cmd_resp_type_o <= '0;
      drv_done_o      <= 1'b0;
      drv_err_o       <= '0;
      acmd_done_o     <= 1'b0;
      drop_drv_q      <= 1'b0;
      drop_acmd_q     <= 1'b0;
    end else if (soft_rst_i) begin
      state           <= ST_IDLE;
      cmd_valid_o     <= 1'b0;
      cmd_index_o     <= '0;
      cmd_arg_o       <= '0;
      cmd_resp_type_o <= '0;
      drv_done_o      <= 1'b0;
      drv_err_o       <= '0;
      acmd_done_o     <= 1'b0;
      drop_drv_q      <= 1'b0;
      drop_acmd_q     <= 1'b0;
    end else begin
      // A dropped command reports completion one cycle after the failing one.
      drv_done_o  <= drop_drv_q;
      acmd_done_o <= drop_acmd_q;
      drop_drv_q  <= 1'b0;
      drop_acmd_q <= 1'b0;
      if (drop_drv_q) drv_err_o <= '0;
      case (state)
        ST_IDLE: begin
          if (acmd_pend || acmd_req_i) begin
            state       <= ST_ISSUE_ACMD;
            cmd_valid_o <= 1'b1;
            {cmd_index_o, cmd_arg_o, cmd_resp_type_o} <= acmd_eff;
          end else if (drv_pend || drv_req_i) begin
            state       <= ST_ISSUE_DRV;
            cmd_valid_o <= 1'b1;
            {cmd_index_o, cmd_arg_o, cmd_resp_type_o} <= drv_eff;
          end
        end
        ST_ISSUE_DRV, ST_ISSUE_ACMD: begin
          if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            state       <= (state == ST_ISSUE_DRV) ? ST_WAIT_DRV : ST_WAIT_ACMD;
          end
        end
        ST_WAIT_DRV: begin
          if (rsp_done_i) begin
            drv_done_o <= 1'b1;
            drv_err_o  <= rsp_err_i;
            state      <= ST_IDLE;
            if (acmd_pend && !rsp_bad) begin
              state       <= ST_ISSUE_ACMD;
              cmd_valid_o <= 1'b1;
              {cmd_index_o, cmd_arg_o, cmd_resp_type_o} <= acmd_eff;
            end else if (acmd_pend) begin
              drop_acmd_q <= 1'b1;
            end
          end
        end
        ST_WAIT_ACMD: begin
          if (rsp_done_i) begin
            acmd_done_o <= 1'b1;
            state       <= ST_IDLE;
            if (drv_pend && !rsp_bad) begin
              state       <= ST_ISSUE_DRV;
              cmd_valid_o <= 1'b1;
              {cmd_index_o, cmd_arg_o, cmd_resp_type_o} <= drv_eff;
            end else if (drv_pend) begin
              drop_drv_q <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_inhibit_o = (state != ST_IDLE) || drv_pend || acmd_pend;
  assign dbg_state_o   = state;

endmodule

// File: tb/tb_sdhci_cmd_arbiter.sv
// Bench for sdhci_cmd_arbiter: transaction-level model of the two requesters
// and the engine, compared against the DUT every cycle, plus directed scenarios.
module tb_sdhci_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        soft_rst_i = 1'b0;
  logic        drv_req_i = 1'b0;
  logic [5:0]  drv_index_i = '0;
  logic [31:0] drv_arg_i = '0;
  logic [1:0]  drv_resp_type_i = '0;
  logic        acmd_req_i = 1'b0;
  logic        cmd_ready_i = 1'b0;
  logic        rsp_done_i = 1'b0;
  logic [3:0]  rsp_err_i = '0;
  logic [7:0]  acmd_err_clr_i = '0;
  logic        drv_done_o, acmd_done_o, cmd_valid_o, cmd_inhibit_o;
  logic [3:0]  drv_err_o;
  logic [5:0]  cmd_index_o;
  logic [31:0] cmd_arg_o;
  logic [1:0]  cmd_resp_type_o;
  logic [7:0]  acmd_err_o;
  logic [2:0]  dbg_state_o;

  sdhci_cmd_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni), .soft_rst_i(soft_rst_i),
    .drv_req_i(drv_req_i), .drv_index_i(drv_index_i), .drv_arg_i(drv_arg_i),
    .drv_resp_type_i(drv_resp_type_i), .drv_done_o(drv_done_o), .drv_err_o(drv_err_o),
    .acmd_req_i(acmd_req_i), .acmd_done_o(acmd_done_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_index_o(cmd_index_o),
    .cmd_arg_o(cmd_arg_o), .cmd_resp_type_o(cmd_resp_type_o),
    .rsp_done_i(rsp_done_i), .rsp_err_i(rsp_err_i), .cmd_inhibit_o(cmd_inhibit_o),
    .acmd_err_o(acmd_err_o), .acmd_err_clr_i(acmd_err_clr_i), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: 0 = line free, 1 = driver command, 2 = Auto CMD12; sent = engine took it
  int          m_owner = 0;
  bit          m_sent = 0;
  bit          m_drv_pend = 0, m_acmd_pend = 0;
  bit          m_late_drv = 0, m_late_acmd = 0;
  logic [5:0]  m_drv_idx = '0;
  logic [31:0] m_drv_arg = '0;
  logic [1:0]  m_drv_type = '0;
  bit          e_valid = 0, e_drv_done = 0, e_acmd_done = 0, e_inhibit = 0;
  logic [3:0]  e_drv_err = '0;
  logic [7:0]  e_acmd_err = '0;
  logic [5:0]  e_idx = '0;
  logic [31:0] e_arg = '0;
  logic [1:0]  e_type = '0;

  always @(posedge clk) begin : model
    logic [7:0] set;
    bit old_drv, old_acmd, bad;
    if (!rst_ni || soft_rst_i) begin
      m_owner = 0; m_sent = 0; m_drv_pend = 0; m_acmd_pend = 0;
      m_late_drv = 0; m_late_acmd = 0;
      e_drv_done = 0; e_acmd_done = 0;
      e_acmd_err = rst_ni ? (e_acmd_err & ~acmd_err_clr_i) : 8'h00;
    end else begin
      set = '0;
      old_drv = m_drv_pend;
      old_acmd = m_acmd_pend;
      bad = (rsp_err_i != 4'h0);
      e_drv_done = m_late_drv;
      e_acmd_done = m_late_acmd;
      if (m_late_drv) e_drv_err = 4'h0;
      m_late_drv = 0;
      m_late_acmd = 0;
      if (drv_req_i && !old_drv) begin
        m_drv_pend = 1;
        m_drv_idx = drv_index_i; m_drv_arg = drv_arg_i; m_drv_type = drv_resp_type_i;
      end
      if (acmd_req_i && !old_acmd) m_acmd_pend = 1;
      if (m_owner != 0 && m_sent && rsp_done_i) begin
        if (m_owner == 1) begin
          e_drv_done = 1; e_drv_err = rsp_err_i; m_drv_pend = 0; m_owner = 0;
          if (old_acmd && !bad) begin m_owner = 2; m_sent = 0; end
          else if (old_acmd) begin m_acmd_pend = 0; m_late_acmd = 1; set[0] = 1; end
        end else begin
          e_acmd_done = 1; set[4:1] = rsp_err_i; m_acmd_pend = 0; m_owner = 0;
          if (old_drv && !bad) begin m_owner = 1; m_sent = 0; end
          else if (old_drv) begin m_drv_pend = 0; m_late_drv = 1; set[7] = 1; end
        end
      end else if (m_owner != 0 && !m_sent && cmd_ready_i) begin
        m_sent = 1;
      end else if (m_owner == 0) begin
        if (m_acmd_pend) begin m_owner = 2; m_sent = 0; end
        else if (m_drv_pend) begin m_owner = 1; m_sent = 0; end
      end
      e_acmd_err = (e_acmd_err & ~acmd_err_clr_i) | set;
    end
    e_valid = (m_owner != 0) && !m_sent;
    e_idx  = (m_owner == 2) ? 6'd12 : m_drv_idx;
    e_arg  = (m_owner == 2) ? 32'h0 : m_drv_arg;
    e_type = (m_owner == 2) ? 2'b11 : m_drv_type;
    e_inhibit = (m_owner != 0) || m_drv_pend || m_acmd_pend;
  end

  // ---------------- per-cycle scoreboard ----------------
  logic [3:0] cap_drv_err = '0;
  int drv_done_cnt = 0, acmd_done_cnt = 0;

  always @(negedge clk) begin
    if (rst_ni) begin
      check("cmd_valid", cmd_valid_o, e_valid);
      if (e_valid) begin
        check("cmd_index", cmd_index_o, e_idx);
        check("cmd_arg", cmd_arg_o, e_arg);
        check("cmd_resp_type", cmd_resp_type_o, e_type);
      end
      check("drv_done", drv_done_o, e_drv_done);
      if (e_drv_done) check("drv_err", drv_err_o, e_drv_err);
      check("acmd_done", acmd_done_o, e_acmd_done);
      check("cmd_inhibit", cmd_inhibit_o, e_inhibit);
      check("acmd_err", acmd_err_o, e_acmd_err);
      if (drv_done_o) begin cap_drv_err = drv_err_o; drv_done_cnt++; end
      if (acmd_done_o) acmd_done_cnt++;
    end
  end

  // ---------------- engine responder ----------------
  int         eng_mode = 2;       // 0 random ready, 1 ready low, 2 ready high
  int         eng_delay = 0;      // 0 = random 1..4 cycles to response
  bit         eng_rand_err = 0;
  logic [3:0] eng_err_q[$];
  logic [5:0] seen_q[$];
  int         rsp_cnt = 0;
  logic [3:0] cur_err = '0;

  initial forever begin : engine
    bit hs, sr;
    @(negedge clk);
    sr = soft_rst_i || !rst_ni;
    hs = cmd_valid_o && cmd_ready_i && !sr;
    if (hs) seen_q.push_back(cmd_index_o);
    @(posedge clk); #1;
    rsp_done_i = 1'b0;
    rsp_err_i = 4'h0;
    if (sr) rsp_cnt = 0;
    else begin
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin rsp_done_i = 1'b1; rsp_err_i = cur_err; end
      end
      if (hs) begin
        rsp_cnt = (eng_delay != 0) ? eng_delay : int'($urandom_range(1, 4));
        if (eng_err_q.size() > 0) cur_err = eng_err_q.pop_front();
        else if (eng_rand_err && $urandom_range(0, 2) == 0) cur_err = 4'($urandom_range(1, 15));
        else cur_err = 4'h0;
      end
    end
    cmd_ready_i = (eng_mode == 2) ? 1'b1 : (eng_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_req(input bit d, input bit a, input logic [5:0] idx,
                           input logic [31:0] arg, input logic [1:0] ty);
    drv_req_i = d; acmd_req_i = a;
    if (d) begin drv_index_i = idx; drv_arg_i = arg; drv_resp_type_i = ty; end
    tick();
    drv_req_i = 1'b0; acmd_req_i = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while (!(m_owner == 0 && !m_drv_pend && !m_acmd_pend && !m_late_drv && !m_late_acmd &&
             rsp_cnt == 0 && !e_drv_done && !e_acmd_done) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("quiet_timeout", 1, 0);
    tick();
  endtask

  task automatic clear_err(input logic [7:0] mask);
    acmd_err_clr_i = mask;
    tick();
    acmd_err_clr_i = 8'h00;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_cmd_valid", cmd_valid_o, 0);
    check("rst_drv_done", drv_done_o, 0);
    check("rst_acmd_done", acmd_done_o, 0);
    check("rst_inhibit", cmd_inhibit_o, 0);
    check("rst_acmd_err", acmd_err_o, 0);
    check("rst_state", dbg_state_o, 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    tick();

    // Same-cycle collision, both clean: ACMD12 first, then the driver command.
    seen_q.delete(); drv_done_cnt = 0; acmd_done_cnt = 0;
    pulse_req(1, 1, 6'd17, 32'hA5A5_0001, 2'b10);
    wait_quiet(100);
    check("s1_seen_n", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      check("s1_first", seen_q[0], 6'd12);
      check("s1_second", seen_q[1], 6'd17);
    end
    check("s1_drv_err", cap_drv_err, 4'h0);
    check("s1_acmd_err", acmd_err_o, 8'h00);
    check("s1_done_cnt", drv_done_cnt + acmd_done_cnt, 2);

    // Driver three cycles ahead of ACMD12.
    seen_q.delete();
    pulse_req(1, 0, 6'd18, 32'h0000_1234, 2'b01);
    tick(); tick();
    pulse_req(0, 1, 6'd0, 32'h0, 2'b00);
    wait_quiet(100);
    check("s2_seen_n", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      check("s2_first", seen_q[0], 6'd18);
      check("s2_second", seen_q[1], 6'd12);
    end
    check("s2_acmd_err", acmd_err_o, 8'h00);

    // Collision, ACMD12 response has crc+index errors: driver command dropped.
    seen_q.delete(); drv_done_cnt = 0; cap_drv_err = 4'hF;
    eng_err_q.push_back(4'b1010);
    pulse_req(1, 1, 6'd19, 32'hCAFE_0000, 2'b10);
    wait_quiet(100);
    check("s3_seen_n", seen_q.size(), 1);
    check("s3_acmd_err", acmd_err_o, 8'h94);
    check("s3_model_err", e_acmd_err, 8'h94);
    check("s3_drv_err", cap_drv_err, 4'h0);
    check("s3_drv_done_cnt", drv_done_cnt, 1);
    clear_err(8'hFF);
    check("s3_cleared", acmd_err_o, 8'h00);

    // Driver first, its response errors: ACMD12 never issued.
    seen_q.delete(); acmd_done_cnt = 0;
    eng_delay = 8;
    eng_err_q.push_back(4'b1010);
    pulse_req(1, 0, 6'd20, 32'h0000_0020, 2'b10);
    tick();
    pulse_req(0, 1, 6'd0, 32'h0, 2'b00);
    wait_quiet(100);
    check("s4_seen_n", seen_q.size(), 1);
    check("s4_drv_err", cap_drv_err, 4'b1010);
    check("s4_acmd_err", acmd_err_o, 8'h01);
    check("s4_acmd_done_cnt", acmd_done_cnt, 1);

    // Software reset while waiting on an ACMD12 response keeps the status.
    eng_delay = 15;
    pulse_req(0, 1, 6'd0, 32'h0, 2'b00);
    n = 0;
    while (!(m_owner == 2 && m_sent) && n < 50) begin tick(); n++; end
    if (n >= 50) check("s6_wait_timeout", 1, 0);
    tick();
    soft_rst_i = 1'b1;
    tick();
    soft_rst_i = 1'b0;
    check("s6_inhibit", cmd_inhibit_o, 0);
    check("s6_state", dbg_state_o, 0);
    check("s6_acmd_err", acmd_err_o, 8'h01);
    tick();
    clear_err(8'h01);
    check("s6_cleared", acmd_err_o, 8'h00);
    eng_delay = 0;
    wait_quiet(50);

    // Engine stalls ready for 20 cycles: command held stable.
    eng_mode = 1;
    pulse_req(1, 0, 6'd33, 32'hDEAD_BEEF, 2'b01);
    for (int i = 0; i < 20; i++) begin
      check("s5_valid", cmd_valid_o, 1);
      check("s5_index", cmd_index_o, 6'd33);
      check("s5_arg", cmd_arg_o, 32'hDEAD_BEEF);
      check("s5_inhibit", cmd_inhibit_o, 1);
      tick();
    end
    eng_mode = 2;
    wait_quiet(100);

    // Randomized traffic.
    eng_mode = 0;
    eng_rand_err = 1;
    for (int i = 0; i < 600; i++) begin
      drv_req_i = ($urandom_range(0, 5) == 0);
      drv_index_i = 6'($urandom_range(0, 63));
      drv_arg_i = $urandom;
      drv_resp_type_i = 2'($urandom_range(0, 3));
      acmd_req_i = ($urandom_range(0, 7) == 0);
      acmd_err_clr_i = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      soft_rst_i = ($urandom_range(0, 59) == 0);
      tick();
    end
    drv_req_i = 1'b0; acmd_req_i = 1'b0; acmd_err_clr_i = 8'h00; soft_rst_i = 1'b0;
    eng_mode = 2;
    wait_quiet(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
